// File: rtl/vga_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_io_ctrl
//  Purpose  : CPU-side I/O controller for the VGA/text display block.
//             Decodes the CRTC index/data pair, the DAC write/read index and
//             data ports and the input status register. It packs the
//             three-byte R,G,B palette protocol into single 32-bit DAC writes.
//             It also holds the cursor, cursor-shape and videomode registers
//             that the scan-out block uses.
//  Ports    : clock, reset        - clock, async active-high reset
//             port_a/i/w/r, port_o - CPU I/O address, write data, strobes,
//                                    registered read data
//             vs, de               - scan-out sync / display enable
//             dac_w*, dac_r*       - palette RAM write / read interface
//             cursor, cursor_sl/sh - cursor position and scanline shape
//             videomode            - 0 = 80x25 text, 2 = 320x200x256
//  Revision : 1.0 - initial release
// ============================================================================
module vga_io_ctrl #(
   parameter int DAC_DEPTH  = 256,
   parameter int CURSOR_MAX = 2047
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [15:0]                        port_a,
   input  logic [7:0]                         port_i,
   input  logic                               port_w,
   input  logic                               port_r,
   output logic [7:0]                         port_o,
   input  logic                               vs,
   input  logic                               de,
   output logic [7:0]                         dac_waddr,
   output logic [31:0]                        dac_wdata,
   output logic                               dac_we,
   output logic [7:0]                         dac_raddr,
   input  logic [31:0]                        dac_rdata,
   output logic [$clog2(CURSOR_MAX+1)-1:0]    cursor,
   output logic [3:0]                         cursor_sl,
   output logic [3:0]                         cursor_sh,
   output logic [1:0]                         videomode
);

   localparam logic [7:0] c_LAST_IDX = 8'(DAC_DEPTH - 1);

   logic [7:0] r_wr_index;
   logic [1:0] r_wr_phase;
   logic [5:0] r_red;
   logic [5:0] r_green;
   logic [7:0] r_rd_index;
   logic [1:0] r_rd_phase;
   logic [7:0] r_crtc_idx;
   logic       r_hide;
   logic [3:0] r_sl;
   logic [3:0] r_sh;

   logic [7:0] w_wr_next;
   logic [7:0] w_rd_next;
   logic [7:0] w_rd_data;
   logic [7:0] w_crtc_data;
   logic       w_unused;

   assign w_wr_next = (r_wr_index == c_LAST_IDX) ? 8'h00 : r_wr_index + 8'd1;
   assign w_rd_next = (r_rd_index == c_LAST_IDX) ? 8'h00 : r_rd_index + 8'd1;

   // The palette read address is simply the read index register.
   assign dac_raddr = r_rd_index;

   // Only the top six bits of each palette byte are visible to the CPU.
   assign w_unused = ^{dac_rdata[31:24], dac_rdata[17:16],
                       dac_rdata[9:8], dac_rdata[1:0]};

   always_comb begin
      w_crtc_data = 8'h00;
      case (r_crtc_idx)
         8'h0A:   w_crtc_data = {2'b00, r_hide, 1'b0, r_sl};
         8'h0B:   w_crtc_data = {4'b0000, r_sh};
         8'h0E:   w_crtc_data = {5'b00000, cursor[10:8]};
         8'h0F:   w_crtc_data = cursor[7:0];
         8'h30:   w_crtc_data = {6'b000000, videomode};
         default: w_crtc_data = 8'h00;
      endcase
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (port_a)
         16'h03C7: w_rd_data = {6'b000000, (r_rd_phase == 2'd0) ? 2'b00 : 2'b11};
         16'h03C8: w_rd_data = r_wr_index;
         16'h03C9: begin
            case (r_rd_phase)
               2'd0:    w_rd_data = {2'b00, dac_rdata[23:18]};
               2'd1:    w_rd_data = {2'b00, dac_rdata[15:10]};
               default: w_rd_data = {2'b00, dac_rdata[7:2]};
            endcase
         end
         16'h03D4: w_rd_data = r_crtc_idx;
         16'h03D5: w_rd_data = w_crtc_data;
         16'h03DA: w_rd_data = {4'b0000, vs, 2'b00, ~de};
         default:  w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         port_o     <= 8'h00;
         dac_we     <= 1'b0;
         dac_waddr  <= 8'h00;
         dac_wdata  <= 32'h0;
         cursor     <= '0;
         cursor_sl  <= 4'd14;
         cursor_sh  <= 4'd15;
         videomode  <= 2'd0;
         r_wr_index <= 8'h00;
         r_wr_phase <= 2'd0;
         r_red      <= 6'd0;
         r_green    <= 6'd0;
         r_rd_index <= 8'h00;
         r_rd_phase <= 2'd0;
         r_crtc_idx <= 8'h00;
         r_hide     <= 1'b0;
         r_sl       <= 4'd14;
         r_sh       <= 4'd15;
      end else begin
         dac_we <= 1'b0;
         // A write wins over a simultaneous read; the read has no effect.
         if (port_w) begin
            case (port_a)
               16'h03C8: begin
                  r_wr_index <= port_i;
                  r_wr_phase <= 2'd0;
               end
               16'h03C9: begin
                  case (r_wr_phase)
                     2'd0: begin
                        r_red      <= port_i[5:0];
                        r_wr_phase <= 2'd1;
                     end
                     2'd1: begin
                        r_green    <= port_i[5:0];
                        r_wr_phase <= 2'd2;
                     end
                     default: begin
                        dac_we     <= 1'b1;
                        dac_waddr  <= r_wr_index;
                        dac_wdata  <= {8'h00, r_red, 2'b00, r_green, 2'b00,
                                       port_i[5:0], 2'b00};
                        r_wr_index <= w_wr_next;
                        r_wr_phase <= 2'd0;
                     end
                  endcase
               end
               16'h03C7: begin
                  r_rd_index <= port_i;
                  r_rd_phase <= 2'd0;
               end
               16'h03D4: r_crtc_idx <= port_i;
               16'h03D5: begin
                  case (r_crtc_idx)
                     8'h0A: begin
                        // Hiding keeps the stored shape so unhiding restores it.
                        r_hide    <= port_i[5];
                        r_sl      <= port_i[3:0];
                        cursor_sl <= port_i[5] ? 4'd15 : port_i[3:0];
                        cursor_sh <= port_i[5] ? 4'd0  : r_sh;
                     end
                     8'h0B: begin
                        r_sh      <= port_i[3:0];
                        cursor_sh <= r_hide ? 4'd0 : port_i[3:0];
                     end
                     8'h0E:   cursor[10:8] <= port_i[2:0];
                     8'h0F:   cursor[7:0]  <= port_i;
                     8'h30:   videomode    <= port_i[1:0];
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end else if (port_r) begin
            port_o <= w_rd_data;
            if (port_a == 16'h03C9) begin
               if (r_rd_phase == 2'd2) begin
                  r_rd_index <= w_rd_next;
                  r_rd_phase <= 2'd0;
               end else begin
                  r_rd_phase <= r_rd_phase + 2'd1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_io_ctrl
//  Purpose  : Self-checking bench for vga_io_ctrl: directed steps plus
//             randomized palette/cursor traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_io_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] port_a;
   logic [7:0]  port_i;
   logic        port_w;
   logic        port_r;
   logic [7:0]  port_o;
   logic        vs;
   logic        de;
   logic [7:0]  dac_waddr;
   logic [31:0] dac_wdata;
   logic        dac_we;
   logic [7:0]  dac_raddr;
   logic [31:0] dac_rdata;
   logic [10:0] cursor;
   logic [3:0]  cursor_sl;
   logic [3:0]  cursor_sh;
   logic [1:0]  videomode;

   int errors = 0;
   int checks = 0;

   logic [31:0] pal [256];
   logic [39:0] log_q [$];

   vga_io_ctrl #(.DAC_DEPTH(256), .CURSOR_MAX(2047)) dut (
      .clock(clock), .reset(reset),
      .port_a(port_a), .port_i(port_i), .port_w(port_w), .port_r(port_r),
      .port_o(port_o), .vs(vs), .de(de),
      .dac_waddr(dac_waddr), .dac_wdata(dac_wdata), .dac_we(dac_we),
      .dac_raddr(dac_raddr), .dac_rdata(dac_rdata),
      .cursor(cursor), .cursor_sl(cursor_sl), .cursor_sh(cursor_sh),
      .videomode(videomode)
   );

   always #5 clock = ~clock;

   // Palette RAM model: one-cycle read latency.
   always @(posedge clock) dac_rdata <= pal[dac_raddr];

   // Every cycle with dac_we high is logged, so a stretched pulse shows up twice.
   always @(negedge clock) if (dac_we) log_q.push_back({dac_waddr, dac_wdata});

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clock);
      port_a = a; port_i = d; port_w = 1'b1;
      @(negedge clock);
      port_w = 1'b0;
      @(negedge clock);
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      @(negedge clock);
      port_a = a; port_r = 1'b1;
      @(negedge clock);
      port_r = 1'b0;
      d = port_o;
      @(negedge clock);
   endtask

   // Palette word from the three CPU bytes, 6 significant bits each.
   function automatic logic [31:0] pal_word(input int r, input int g, input int b);
      return 32'(((r % 64) * 4) * 65536 + ((g % 64) * 4) * 256 + (b % 64) * 4);
   endfunction

   initial begin
      logic [7:0]  d;
      logic [7:0]  bytes [$];
      int          base, k, idx, cval, shift;

      for (int i = 0; i < 256; i++) pal[i] = $urandom;
      reset = 1'b1; port_a = 16'h0; port_i = 8'h0; port_w = 1'b0; port_r = 1'b0;
      vs = 1'b0; de = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_port_o", 40'(port_o), 40'h00);
      chk("rst_shape", 40'({cursor_sl, cursor_sh, videomode, dac_we}), 40'({4'd14, 4'd15, 2'd0, 1'b0}));
      chk("rst_cursor", 40'(cursor), 40'h0);
      reset = 1'b0;
      @(negedge clock);

      // Reset in the middle of a palette triple.
      wr(16'h03D4, 8'h0A); wr(16'h03D5, 8'h03);
      wr(16'h03D4, 8'h30); wr(16'h03D5, 8'h02);
      wr(16'h03C8, 8'h40); wr(16'h03C9, 8'h11); wr(16'h03C9, 8'h22);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("midrst_no_we", 40'(log_q.size()), 40'd0);
      chk("midrst_regs", 40'({cursor_sl, cursor_sh, videomode}), 40'({4'd14, 4'd15, 2'd0}));
      wr(16'h03C9, 8'h01); wr(16'h03C9, 8'h02); wr(16'h03C9, 8'h03);
      chk("midrst_cnt", 40'(log_q.size()), 40'd1);
      if (log_q.size() > 0) chk("midrst_word", log_q[0], {8'h00, pal_word(1, 2, 3)});
      log_q.delete();

      // Index wrap at 0xFF.
      wr(16'h03C8, 8'hFF); wr(16'h03C9, 8'h3F); wr(16'h03C9, 8'h20); wr(16'h03C9, 8'hC1);
      wr(16'h03C9, 8'h05); wr(16'h03C9, 8'h06); wr(16'h03C9, 8'h07);
      chk("wrap_cnt", 40'(log_q.size()), 40'd2);
      if (log_q.size() == 2) begin
         chk("wrap_w0", log_q[0], {8'hFF, 32'h00FC8004});
         chk("wrap_w1", log_q[1], {8'h00, pal_word(5, 6, 7)});
      end
      rd(16'h03C8, d);
      chk("wr_index_rd", 40'(d), 40'h01);
      log_q.delete();

      // Palette read-back.
      pal[5] = 32'h00FC8004;
      wr(16'h03C7, 8'd5);
      rd(16'h03C9, d); chk("rd_R", 40'(d), 40'h3F);
      rd(16'h03C7, d); chk("rd_status", 40'(d), 40'h03);
      rd(16'h03C9, d); chk("rd_G", 40'(d), 40'h20);
      rd(16'h03C9, d); chk("rd_B", 40'(d), 40'h01);
      chk("raddr_inc", 40'(dac_raddr), 40'd6);
      rd(16'h03C7, d); chk("rd_status0", 40'(d), 40'h00);

      // CRTC cursor and shape.
      wr(16'h03D4, 8'h0E); wr(16'h03D5, 8'h07);
      wr(16'h03D4, 8'h0F); wr(16'h03D5, 8'hD0);
      chk("cursor", 40'(cursor), 40'h7D0);
      wr(16'h03D4, 8'h0A); wr(16'h03D5, 8'h26);
      chk("hide", 40'({cursor_sl, cursor_sh}), 40'({4'd15, 4'd0}));
      rd(16'h03D5, d); chk("rd_0A", 40'(d), 40'h26);
      wr(16'h03D5, 8'h06);
      chk("unhide", 40'({cursor_sl, cursor_sh}), 40'({4'd6, 4'd15}));
      rd(16'h03D4, d); chk("rd_3D4", 40'(d), 40'h0A);

      // Videomode and status register.
      wr(16'h03D4, 8'h30); wr(16'h03D5, 8'h02);
      chk("videomode", 40'(videomode), 40'd2);
      vs = 1'b1; de = 1'b0;
      rd(16'h03DA, d); chk("status_vs", 40'(d), 40'h09);
      vs = 1'b0; de = 1'b1;

      // Simultaneous write and read: write wins, port_o holds 0x09.
      wr(16'h03C8, 8'h80);
      @(negedge clock);
      port_a = 16'h03C9; port_i = 8'h0A; port_w = 1'b1; port_r = 1'b1;
      @(negedge clock);
      port_w = 1'b0; port_r = 1'b0;
      chk("wr_rd_hold", 40'(port_o), 40'h09);
      @(negedge clock);
      wr(16'h03C9, 8'h0B); wr(16'h03C9, 8'h0C);
      chk("wr_rd_cnt", 40'(log_q.size()), 40'd1);
      if (log_q.size() == 1) chk("wr_rd_word", log_q[0], {8'h80, pal_word(10, 11, 12)});
      log_q.delete();
      rd(16'h03DA, d); chk("status_de", 40'(d), 40'h00);
      rd(16'h1234, d); chk("undecoded", 40'(d), 40'h00);

      // Randomized palette writes: every complete triple is one write.
      for (int round = 0; round < 4; round++) begin
         base = (round == 0) ? 254 : int'($urandom_range(0, 255));
         k = int'($urandom_range(1, 5));
         bytes.delete();
         log_q.delete();
         wr(16'h03C8, 8'(base));
         for (int j = 0; j < 3 * k + int'($urandom_range(0, 2)); j++) begin
            bytes.push_back(8'($urandom));
            wr(16'h03C9, bytes[j]);
         end
         chk("rnd_wr_cnt", 40'(log_q.size()), 40'(k));
         for (int t = 0; t < k && t < log_q.size(); t++)
            chk("rnd_wr_word", log_q[t],
                {8'((base + t) % 256), pal_word(bytes[3*t], bytes[3*t+1], bytes[3*t+2])});
      end

      // Randomized palette reads across two entries.
      for (int round = 0; round < 3; round++) begin
         idx = (round == 0) ? 255 : int'($urandom_range(0, 255));
         wr(16'h03C7, 8'(idx));
         for (int j = 0; j < 6; j++) begin
            shift = 18 - 8 * (j % 3);
            rd(16'h03C9, d);
            chk("rnd_rd", 40'(d), 40'((pal[(idx + j / 3) % 256] >> shift) % 64));
         end
         chk("rnd_raddr", 40'(dac_raddr), 40'((idx + 2) % 256));
      end

      // Randomized cursor positions.
      for (int round = 0; round < 4; round++) begin
         cval = int'($urandom_range(0, 2047));
         wr(16'h03D4, 8'h0E); wr(16'h03D5, 8'(cval / 256) | 8'hF8);
         wr(16'h03D4, 8'h0F); wr(16'h03D5, 8'(cval % 256));
         chk("rnd_cursor", 40'(cursor), 40'(cval));
         rd(16'h03D5, d);
         chk("rnd_cur_lo", 40'(d), 40'(cval % 256));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
